// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, ALU op encodings, decode FSM states
// and the instruction decode function used by decode_stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RT   = 2'd1,
    DEST_RD   = 2'd2
  } dest_sel_t;

  typedef struct packed {
    alu_op_t   alu_op;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      is_branch;
    logic      illegal;
    logic      use_imm;
    dest_sel_t dest_sel;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    c.alu_op   = ALU_ADD;
    c.dest_sel = DEST_NONE;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.dest_sel  = DEST_RD;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.use_imm   = 1'b1;
        c.dest_sel  = DEST_RT;
      end
      OP_LW: begin
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
        c.use_imm   = 1'b1;
        c.dest_sel  = DEST_RT;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.use_imm   = 1'b1;
      end
      OP_BEQ: begin
        c.alu_op    = ALU_SUB;
        c.is_branch = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    // An unsupported encoding must not disturb memory or the register file downstream.
    if (c.illegal) begin
      c.mem_read  = 1'b0;
      c.mem_write = 1'b0;
      c.reg_write = 1'b0;
      c.is_branch = 1'b0;
      c.use_imm   = 1'b0;
      c.dest_sel  = DEST_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module reg_file #(
  parameter  int REG_COUNT = 32,
  parameter  int DATA_W    = 32,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [REG_COUNT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: latches the fetched instruction, reads operands (with writeback bypass)
// and issues registered control/operands with a one-cycle stage3 token.
//   state    | meaning
//   ST_IDLE  | waiting for stage_in; IR loads on the token
//   ST_READ  | decode + register read captured into the pending set
//   ST_ISSUE | pending set moves to the outputs, stage_out pulses next cycle
module decode_stage
  import mips_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stage_in,
  input  logic [31:0]       instruction,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stage_out,
  output logic              busy,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        dest_reg,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              is_branch,
  output logic              illegal
);

  state_t            state, state_nxt;
  logic [31:0]       ir;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rf_a, rf_b, rs_val, rt_val, imm_ext;
  ctrl_t             ctrl, p_ctrl;
  logic [DATA_W-1:0] p_a, p_b, p_store;
  logic [4:0]        p_dest, dest_nxt;

  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign imm_ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign ctrl    = decode(ir[31:26], ir[5:0]);
  assign busy    = (state != ST_IDLE);

  reg_file #(.REG_COUNT(REG_COUNT), .DATA_W(DATA_W)) u_reg_file (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs),
    .rd_data_a (rf_a),
    .rd_addr_b (rt),
    .rd_data_b (rf_b)
  );

  // Same-cycle writeback would otherwise be missed by the array read.
  assign rs_val = (wb_en && wb_addr == rs && rs != 5'd0) ? wb_data : rf_a;
  assign rt_val = (wb_en && wb_addr == rt && rt != 5'd0) ? wb_data : rf_b;

  always_comb begin
    dest_nxt = 5'd0;
    case (ctrl.dest_sel)
      DEST_RT: dest_nxt = rt;
      DEST_RD: dest_nxt = rd;
      default: dest_nxt = 5'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (stage_in) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir         <= '0;
      p_ctrl     <= '0;
      p_a        <= '0;
      p_b        <= '0;
      p_store    <= '0;
      p_dest     <= '0;
      stage_out  <= 1'b0;
      alu_op     <= '0;
      operand_a  <= '0;
      operand_b  <= '0;
      store_data <= '0;
      dest_reg   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      is_branch  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      stage_out <= 1'b0;
      if (state == ST_IDLE && stage_in) ir <= instruction;
      if (state == ST_READ) begin
        p_ctrl  <= ctrl;
        p_a     <= rs_val;
        p_b     <= ctrl.use_imm ? imm_ext : rt_val;
        p_store <= rt_val;
        p_dest  <= dest_nxt;
      end
      if (state == ST_ISSUE) begin
        stage_out  <= 1'b1;
        alu_op     <= p_ctrl.alu_op;
        operand_a  <= p_a;
        operand_b  <= p_b;
        store_data <= p_store;
        dest_reg   <= p_dest;
        mem_read   <= p_ctrl.mem_read;
        mem_write  <= p_ctrl.mem_write;
        reg_write  <= p_ctrl.reg_write;
        is_branch  <= p_ctrl.is_branch;
        illegal    <= p_ctrl.illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed instruction vectors, bypass, busy, reset abort.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stage_in;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stage_out, busy;
  logic [2:0]  alu_op;
  logic [31:0] operand_a, operand_b, store_data;
  logic [4:0]  dest_reg;
  logic        mem_read, mem_write, reg_write, is_branch, illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  decode_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stage_in    (stage_in),
    .instruction (instruction),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .stage_out   (stage_out),
    .busy        (busy),
    .alu_op      (alu_op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .store_data  (store_data),
    .dest_reg    (dest_reg),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .is_branch   (is_branch),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clock);
    wb_en = 1'b0;
  endtask

  // Entered on a negedge with the DUT idle; returns on the negedge where stage_out should be high.
  task automatic issue(input string tag, input logic [31:0] instr, input logic do_wb,
                       input logic [4:0] wa, input logic [31:0] wd);
    stage_in = 1'b1; instruction = instr;
    @(negedge clock);
    stage_in = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (do_wb) begin
      wb_en = 1'b1; wb_addr = wa; wb_data = wd;
    end
    @(negedge clock);
    wb_en = 1'b0;
    chk({tag, "_early"}, {31'd0, stage_out}, 32'd0);
    @(negedge clock);
    chk({tag, "_token"}, {31'd0, stage_out}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stage_in = 1'b0; instruction = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clock);
    stage_in = 1'b1; instruction = 32'h00221820;
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_token", {31'd0, stage_out}, 32'd0);
    chk("rst_opa", operand_a, 32'd0);
    chk("rst_ctrl", {27'd0, reg_write, mem_read, mem_write, is_branch, illegal}, 32'd0);
    stage_in = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue("add", 32'h00221820, 1'b0, 5'd0, 32'd0);
    chk("add_opa", operand_a, 32'd5);
    chk("add_opb", operand_b, 32'd7);
    chk("add_alu", {29'd0, alu_op}, 32'd0);
    chk("add_dest", {27'd0, dest_reg}, 32'd3);
    chk("add_rw", {31'd0, reg_write}, 32'd1);
    chk("add_ill", {31'd0, illegal}, 32'd0);
    @(negedge clock);
    chk("hold_token", {31'd0, stage_out}, 32'd0);
    chk("hold_opa", operand_a, 32'd5);

    wb_write(5'd1, 32'h100);
    issue("lw", 32'h8C24FFFC, 1'b0, 5'd0, 32'd0);
    chk("lw_opa", operand_a, 32'h100);
    chk("lw_opb", operand_b, 32'hFFFFFFFC);
    chk("lw_mr", {31'd0, mem_read}, 32'd1);
    chk("lw_dest", {27'd0, dest_reg}, 32'd4);
    chk("lw_alu", {29'd0, alu_op}, 32'd0);

    issue("sub_byp", 32'h00222822, 1'b1, 5'd2, 32'h55);
    chk("byp_opb", operand_b, 32'h55);
    chk("byp_alu", {29'd0, alu_op}, 32'd1);
    chk("byp_dest", {27'd0, dest_reg}, 32'd5);

    wb_write(5'd0, 32'hFFFF);
    issue("or0", 32'h00003025, 1'b0, 5'd0, 32'd0);
    chk("or0_opa", operand_a, 32'd0);
    chk("or0_opb", operand_b, 32'd0);
    chk("or0_alu", {29'd0, alu_op}, 32'd3);

    issue("badop", 32'hFC000000, 1'b0, 5'd0, 32'd0);
    chk("badop_ill", {31'd0, illegal}, 32'd1);
    chk("badop_ctrl", {27'd0, reg_write, mem_read, mem_write, is_branch, 1'b0}, 32'd0);
    chk("badop_dest", {27'd0, dest_reg}, 32'd0);

    issue("badfn", 32'h00221821, 1'b0, 5'd0, 32'd0);
    chk("badfn_ill", {31'd0, illegal}, 32'd1);
    chk("badfn_dest", {27'd0, dest_reg}, 32'd0);

    issue("sw", 32'hAC220008, 1'b0, 5'd0, 32'd0);
    chk("sw_opb", operand_b, 32'd8);
    chk("sw_store", store_data, 32'h55);
    chk("sw_ctrl", {27'd0, reg_write, mem_read, mem_write, is_branch, illegal}, 32'b00100);
    chk("sw_dest", {27'd0, dest_reg}, 32'd0);

    issue("beq", 32'h1022FFFF, 1'b0, 5'd0, 32'd0);
    chk("beq_opb", operand_b, 32'h55);
    chk("beq_alu", {29'd0, alu_op}, 32'd1);
    chk("beq_ctrl", {27'd0, reg_write, mem_read, mem_write, is_branch, illegal}, 32'b00010);

    issue("addi", 32'h2027FFFE, 1'b0, 5'd0, 32'd0);
    chk("addi_opb", operand_b, 32'hFFFFFFFE);
    chk("addi_dest", {27'd0, dest_reg}, 32'd7);

    // Extra stage_in pulses while busy must be ignored.
    stage_in = 1'b1; instruction = 32'h00224024;
    @(negedge clock);
    instruction = 32'h00221820;
    @(negedge clock);
    @(negedge clock);
    stage_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (stage_out) pulses++;
      @(negedge clock);
    end
    chk("busy_pulses", pulses, 32'd1);
    chk("busy_alu", {29'd0, alu_op}, 32'd2);
    chk("busy_dest", {27'd0, dest_reg}, 32'd8);

    stage_in = 1'b1; instruction = 32'h00221820;
    @(negedge clock);
    stage_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_opa", operand_a, 32'd0);
    chk("abort_dest", {27'd0, dest_reg}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (stage_out) pulses++;
    end
    chk("abort_pulses", pulses, 32'd0);
    issue("post_rst", 32'h00201820, 1'b0, 5'd0, 32'd0);
    chk("post_rst_r1", operand_a, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
